// File: rtl/dma_burst_fifo.sv
// Single-clock DMA burst FIFO with occupancy/threshold flags, sticky error flags,
// synchronous flush and a choice of registered or fall-through read data.
module dma_burst_fifo #(
   parameter int FIFO_WIDTH   = 16,
   parameter int FIFO_DEPTH   = 8,
   parameter int FALL_THROUGH = 0,
   parameter int AF_LEVEL     = FIFO_DEPTH - 2,
   parameter int AE_LEVEL     = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [FIFO_WIDTH-1:0]         data_in,
   input  logic                          wr_en,
   input  logic                          rd_en,
   input  logic                          flush,
   output logic [FIFO_WIDTH-1:0]         data_out,
   output logic                          rd_valid,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   // Handshake: wr_en/rd_en are requests sampled every rising edge. A request is
   // accepted (wr_acc/rd_acc) only when the FIFO can honour it in that cycle; a
   // rejected request is dropped and recorded in the sticky overflow/underflow
   // flag. rd_valid marks the cycles in which data_out carries a popped word.
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic                  full_w, empty_w;
   logic                  rd_acc, wr_acc;

   assign full_w  = (count_q == CW'(FIFO_DEPTH));
   assign empty_w = (count_q == '0);

   // Flush blocks both sides; a full FIFO still takes a write paired with a read.
   assign rd_acc = rd_en && !empty_w && !flush;
   assign wr_acc = wr_en && (!full_w || rd_acc) && !flush;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (wr_en && !wr_acc) overflow_d  = 1'b1;
         if (rd_en && empty_w) underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left out of reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= data_in;
   end

   generate
      if (FALL_THROUGH != 0) begin : g_ft
         assign data_out = mem_q[rd_ptr_q];
         assign rd_valid = !empty_w;
      end else begin : g_reg
         logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
         logic                  rd_valid_q, rd_valid_d;

         always_comb begin
            data_out_d = data_out_q;
            rd_valid_d = 1'b0;
            if (rd_acc) begin
               data_out_d = mem_q[rd_ptr_q];
               rd_valid_d = 1'b1;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data_out_q <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               data_out_q <= data_out_d;
               rd_valid_q <= rd_valid_d;
            end
         end

         assign data_out = data_out_q;
         assign rd_valid = rd_valid_q;
      end
   endgenerate

   assign full         = full_w;
   assign empty        = empty_w;
   assign almost_full  = (count_q >= CW'(AF_LEVEL));
   assign almost_empty = (count_q <= CW'(AE_LEVEL));
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_dma_burst_fifo.sv
// Bench for dma_burst_fifo: a registered and a fall-through instance share stimulus
// and are checked against a queue model plus a table of directed vectors.
module tb_dma_burst_fifo;

   localparam int W = 16;
   localparam int D = 8;

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  data_in;
   logic          wr_en, rd_en, flush;

   logic [W-1:0]  data_out, ft_data_out;
   logic          rd_valid, ft_rd_valid;
   logic          full, ft_full, empty, ft_empty;
   logic          almost_full, ft_almost_full, almost_empty, ft_almost_empty;
   logic [3:0]    count, ft_count;
   logic          overflow, ft_overflow, underflow, ft_underflow;

   dma_burst_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FALL_THROUGH(0)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
      .flush(flush), .data_out(data_out), .rd_valid(rd_valid), .full(full),
      .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow));

   dma_burst_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FALL_THROUGH(1)) dut_ft (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
      .flush(flush), .data_out(ft_data_out), .rd_valid(ft_rd_valid), .full(ft_full),
      .empty(ft_empty), .almost_full(ft_almost_full), .almost_empty(ft_almost_empty),
      .count(ft_count), .overflow(ft_overflow), .underflow(ft_underflow));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   // ---------------- scoreboard / model ----------------
   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];
   logic         m_ovf, m_unf, m_rv;
   logic [W-1:0] m_dout;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_rv   = 1'b0;
      m_dout = '0;
   endtask

   task automatic model_step(input logic fl, input logic wr, input logic rd, input logic [W-1:0] din);
      logic r_ok, w_ok;
      if (fl) begin
         exp_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         m_rv  = 1'b0;
      end else begin
         r_ok = rd && (exp_q.size() != 0);
         w_ok = wr && ((exp_q.size() < D) || r_ok);
         if (rd && exp_q.size() == 0) m_unf = 1'b1;
         if (wr && !w_ok) m_ovf = 1'b1;
         m_rv = r_ok;
         if (r_ok) m_dout = exp_q.pop_front();
         if (w_ok) exp_q.push_back(din);
      end
   endtask

   task automatic check_model();
      int n;
      n = exp_q.size();
      chk("m_count", 32'(count), 32'(n));
      chk("m_full", 32'(full), 32'(n == D));
      chk("m_empty", 32'(empty), 32'(n == 0));
      chk("m_afull", 32'(almost_full), 32'(n >= D - 2));
      chk("m_aempty", 32'(almost_empty), 32'(n <= 1));
      chk("m_ovf", 32'(overflow), 32'(m_ovf));
      chk("m_unf", 32'(underflow), 32'(m_unf));
      chk("m_rvalid", 32'(rd_valid), 32'(m_rv));
      chk("m_dout", 32'(data_out), 32'(m_dout));
      chk("m_ft_count", 32'(ft_count), 32'(n));
      chk("m_ft_rvalid", 32'(ft_rd_valid), 32'(n != 0));
      if (n != 0) chk("m_ft_dout", 32'(ft_data_out), 32'(exp_q[0]));
   endtask

   // ---------------- driver ----------------
   task automatic cycle(input logic fl, input logic wr, input logic rd, input logic [W-1:0] din);
      flush   = fl;
      wr_en   = wr;
      rd_en   = rd;
      data_in = din;
      @(posedge clk);
      model_step(fl, wr, rd, din);
      #1;
      check_model();
      flush = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic         fl, wr, rd;
      logic [W-1:0] din;
      int           cnt;
      logic [W-1:0] dout;
      logic         rv, ovf, unf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic fl, input logic wr, input logic rd, input logic [W-1:0] din,
                      input int cnt, input logic [W-1:0] dout, input logic rv,
                      input logic ovf, input logic unf);
      vec_t v;
      v.fl = fl; v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt;
      v.dout = dout; v.rv = rv; v.ovf = ovf; v.unf = unf;
      vecs.push_back(v);
   endtask

   initial begin
      logic wr, rd;
      int   n;

      // Fill 0x0001..0x0008, drain in order, one idle cycle.
      for (int k = 1; k <= 8; k++) add(0, 1, 0, 16'(k), k, 16'h0000, 0, 0, 0);
      for (int k = 1; k <= 8; k++) add(0, 0, 1, 16'h0, 8 - k, 16'(k), 1, 0, 0);
      add(0, 0, 0, 16'h0, 0, 16'h0008, 0, 0, 0);
      // Full FIFO, simultaneous write+read of 0x00AA.
      for (int k = 1; k <= 8; k++) add(0, 1, 0, 16'(16'h10 + k), k, 16'h0008, 0, 0, 0);
      add(0, 1, 1, 16'h00AA, 8, 16'h0011, 1, 0, 0);
      for (int k = 2; k <= 8; k++) add(0, 0, 1, 16'h0, 9 - k, 16'(16'h10 + k), 1, 0, 0);
      add(0, 0, 1, 16'h0, 0, 16'h00AA, 1, 0, 0);
      // Full FIFO, write alone overflows; head intact; flush beats wr/rd.
      for (int k = 1; k <= 8; k++) add(0, 1, 0, 16'(16'h20 + k), k, 16'h00AA, 0, 0, 0);
      add(0, 1, 0, 16'h0099, 8, 16'h00AA, 0, 1, 0);
      add(0, 0, 1, 16'h0, 7, 16'h0021, 1, 1, 0);
      add(1, 1, 1, 16'h0077, 0, 16'h0021, 0, 0, 0);
      // Empty FIFO, read+write together: read rejected, write taken.
      add(0, 1, 1, 16'h1234, 1, 16'h0021, 0, 0, 1);
      add(0, 0, 1, 16'h0, 0, 16'h1234, 1, 0, 1);
      add(1, 0, 0, 16'h0, 0, 16'h1234, 0, 0, 0);

      rst_n = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_model();
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_aempty", 32'(almost_empty), 32'd1);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      foreach (vecs[i]) begin
         cycle(vecs[i].fl, vecs[i].wr, vecs[i].rd, vecs[i].din);
         chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
         chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].cnt == 8));
         chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].cnt == 0));
         chk($sformatf("v%0d_afull", i), 32'(almost_full), 32'(vecs[i].cnt >= 6));
         chk($sformatf("v%0d_aempty", i), 32'(almost_empty), 32'(vecs[i].cnt <= 1));
         chk($sformatf("v%0d_dout", i), 32'(data_out), 32'(vecs[i].dout));
         chk($sformatf("v%0d_rvalid", i), 32'(rd_valid), 32'(vecs[i].rv));
         chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
         chk($sformatf("v%0d_unf", i), 32'(underflow), 32'(vecs[i].unf));
      end

      // Fall-through: written word visible the next cycle, gone after the read.
      cycle(0, 1, 0, 16'h00C3);
      chk("ft_dout_c3", 32'(ft_data_out), 32'h00C3);
      chk("ft_rvalid_hi", 32'(ft_rd_valid), 32'd1);
      cycle(0, 0, 1, 16'h0);
      chk("ft_empty", 32'(ft_empty), 32'd1);
      chk("ft_rvalid_lo", 32'(ft_rd_valid), 32'd0);

      // Interleaved traffic held between 3 and 5 entries, then async reset.
      for (int k = 0; k < 4; k++) cycle(0, 1, 0, 16'($urandom_range(0, 16'hFFFF)));
      for (int k = 0; k < 20; k++) begin
         n  = exp_q.size();
         wr = 1'($urandom_range(0, 1));
         rd = 1'($urandom_range(0, 1));
         if (n >= 5 && wr && !rd) wr = 1'b0;
         if (n <= 3 && rd && !wr) rd = 1'b0;
         cycle(0, wr, rd, 16'($urandom_range(0, 16'hFFFF)));
      end
      chk("mid_not_empty", 32'(empty), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_model();
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_ft_empty", 32'(ft_empty), 32'd1);
      @(posedge clk);
      #3 rst_n = 1'b1;
      cycle(0, 1, 0, 16'h5A5A);
      chk("arst_addr0", 32'(dut.mem_q[0]), 32'h5A5A);
      cycle(0, 0, 1, 16'h0);
      chk("arst_read", 32'(data_out), 32'h5A5A);

      // Long random run with occasional flush and async reset.
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 199) == 0) begin
            #2 rst_n = 1'b0;
            #1;
            model_reset();
            check_model();
            @(posedge clk);
            #3 rst_n = 1'b1;
         end
         cycle($urandom_range(0, 39) == 0,
               $urandom_range(0, 99) < 55,
               $urandom_range(0, 99) < 50,
               16'($urandom_range(0, 16'hFFFF)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
